// File: rtl/aes_block_scheduler_if.sv
// Handshake bundle between the block scheduler and the source streamer,
// the AES engine and the sink streamer.
interface aes_block_scheduler_if #(
  parameter int ADDR_W = 32
);
  logic              src_req_valid;
  logic              src_req_ready;
  logic [ADDR_W-1:0] src_req_addr;
  logic              src_done;
  logic              eng_key_start;
  logic              eng_key_done;
  logic              eng_start;
  logic              eng_done;
  logic              dst_req_valid;
  logic              dst_req_ready;
  logic [ADDR_W-1:0] dst_req_addr;
  logic              dst_done;

  modport master (
    output src_req_valid, src_req_addr, eng_key_start, eng_start,
           dst_req_valid, dst_req_addr,
    input  src_req_ready, src_done, eng_key_done, eng_done,
           dst_req_ready, dst_done
  );

  modport slave (
    input  src_req_valid, src_req_addr, eng_key_start, eng_start,
           dst_req_valid, dst_req_addr,
    output src_req_ready, src_done, eng_key_done, eng_done,
           dst_req_ready, dst_done
  );
endinterface

// File: rtl/aes_block_scheduler.sv
// Walks the AES engine over a job of N 128-bit blocks: optional key expansion,
// then load / encrypt / store per block, with abort and a completion pulse.
module aes_block_scheduler #(
  parameter int ADDR_W    = 32,
  parameter int CNT_W     = 16,
  parameter int BLK_BYTES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [CNT_W-1:0]      num_blocks,
  input  logic [ADDR_W-1:0]     src_base,
  input  logic [ADDR_W-1:0]     dst_base,
  input  logic                  key_reload,
  aes_block_scheduler_if.master bus,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      blocks_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEY,
    S_LOAD,
    S_RUN,
    S_STORE,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(BLK_BYTES);

  state_t            state, state_n;
  logic [CNT_W-1:0]  num_q, num_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic [ADDR_W-1:0] src_addr_q, src_addr_n;
  logic [ADDR_W-1:0] dst_addr_q, dst_addr_n;
  logic              sent_q, sent_n;
  logic              src_vld_q, dst_vld_q;
  logic              key_start_q, eng_start_q;
  logic              busy_q, done_q;
  logic              src_xfer, dst_xfer;
  logic [CNT_W:0]    cnt_inc;
  logic              last_blk;

  assign src_xfer = src_vld_q & bus.src_req_ready;
  assign dst_xfer = dst_vld_q & bus.dst_req_ready;

  // One extra bit so a job of 2**CNT_W-1 blocks compares before the counter wraps.
  assign cnt_inc  = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  assign last_blk = (cnt_inc == {1'b0, num_q});

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n    = state;
    num_n      = num_q;
    cnt_n      = cnt_q;
    src_addr_n = src_addr_q;
    dst_addr_n = dst_addr_q;
    sent_n     = sent_q;
    if ((state != S_IDLE) && abort) begin
      state_n = S_IDLE;
      sent_n  = 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            num_n      = num_blocks;
            cnt_n      = '0;
            src_addr_n = src_base;
            dst_addr_n = dst_base;
            sent_n     = 1'b0;
            if (num_blocks == '0) state_n = S_DONE;
            else if (key_reload)  state_n = S_KEY;
            else                  state_n = S_LOAD;
          end
        end
        S_KEY: begin
          if (bus.eng_key_done) state_n = S_LOAD;
        end
        S_LOAD: begin
          // sent_q remembers the accepted request while waiting for src_done.
          if (src_xfer) sent_n = 1'b1;
          if ((sent_q || src_xfer) && bus.src_done) begin
            sent_n  = 1'b0;
            state_n = S_RUN;
          end
        end
        S_RUN: begin
          if (bus.eng_done) state_n = S_STORE;
        end
        S_STORE: begin
          if (dst_xfer) sent_n = 1'b1;
          if ((sent_q || dst_xfer) && bus.dst_done) begin
            sent_n     = 1'b0;
            cnt_n      = cnt_inc[CNT_W-1:0];
            src_addr_n = src_addr_q + STEP;
            dst_addr_n = dst_addr_q + STEP;
            state_n    = last_blk ? S_DONE : S_LOAD;
          end
        end
        S_DONE:  state_n = S_IDLE;
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next-state view so they line up with the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      num_q       <= '0;
      cnt_q       <= '0;
      src_addr_q  <= '0;
      dst_addr_q  <= '0;
      sent_q      <= 1'b0;
      src_vld_q   <= 1'b0;
      dst_vld_q   <= 1'b0;
      key_start_q <= 1'b0;
      eng_start_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      num_q       <= num_n;
      cnt_q       <= cnt_n;
      src_addr_q  <= src_addr_n;
      dst_addr_q  <= dst_addr_n;
      sent_q      <= sent_n;
      src_vld_q   <= (state_n == S_LOAD)  && !sent_n;
      dst_vld_q   <= (state_n == S_STORE) && !sent_n;
      key_start_q <= (state_n == S_KEY)   && (state != S_KEY);
      eng_start_q <= (state_n == S_RUN)   && (state != S_RUN);
      busy_q      <= (state_n != S_IDLE);
      done_q      <= (state_n == S_DONE);
    end
  end

  assign bus.src_req_valid = src_vld_q;
  assign bus.src_req_addr  = src_addr_q;
  assign bus.dst_req_valid = dst_vld_q;
  assign bus.dst_req_addr  = dst_addr_q;
  assign bus.eng_key_start = key_start_q;
  assign bus.eng_start     = eng_start_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign blocks_done       = cnt_q;

endmodule

// File: tb/tb_aes_block_scheduler.sv
// Bench for aes_block_scheduler: responder models for streamers and engine, an
// event-log reference model, a directed vector table and randomized jobs.
module tb_aes_block_scheduler;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = 5;
  localparam int BLK    = 16;

  // Event codes in the observed / expected job log.
  localparam int EV_KEY = 1, EV_SRC = 2, EV_ENG = 3, EV_DST = 4, EV_DONE = 5;

  logic              clk = 1'b0;
  logic              reset, start, abort, key_reload;
  logic [CNT_W-1:0]  num_blocks;
  logic [ADDR_W-1:0] src_base, dst_base;
  logic              busy, done;
  logic [CNT_W-1:0]  blocks_done;

  aes_block_scheduler_if #(.ADDR_W(ADDR_W)) bus ();

  aes_block_scheduler #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .BLK_BYTES(BLK)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .num_blocks(num_blocks), .src_base(src_base), .dst_base(dst_base),
    .key_reload(key_reload), .bus(bus),
    .busy(busy), .done(done), .blocks_done(blocks_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          num;
    logic [31:0] src;
    logic [31:0] dst;
    bit          key;
    int          stall;
    logic [31:0] last_src;
    logic [31:0] last_dst;
    int          blocks;
  } vec_t;

  int          checks = 0, errors = 0;
  int          ev_log[$], exp_ev[$];
  logic [31:0] src_log[$], dst_log[$], exp_src[$], exp_dst[$];
  int          stab_err = 0;
  int          stall_min = 0, stall_max = 0;
  int          src_lat = 1, dst_lat = 1, eng_lat = 1, key_lat = 1;
  bit          same_cyc = 1'b0, dst_hold = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic int count_ev(input int e);
    int c = 0;
    foreach (ev_log[i]) if (ev_log[i] == e) c++;
    return c;
  endfunction

  // Streamer and engine responders plus the bus monitor, all on the falling edge.
  initial begin : slaves
    int          src_stall, dst_stall, src_dly, dst_dly, eng_dly, key_dly;
    bit          src_new, dst_new, src_stalled, dst_stalled, kill;
    logic [31:0] src_hold_addr, dst_hold_addr;
    src_stall = 0; dst_stall = 0; src_dly = 0; dst_dly = 0; eng_dly = 0; key_dly = 0;
    src_new = 1'b1; dst_new = 1'b1; src_stalled = 1'b0; dst_stalled = 1'b0;
    src_hold_addr = '0; dst_hold_addr = '0;
    bus.src_req_ready = 1'b0; bus.src_done = 1'b0; bus.eng_key_done = 1'b0;
    bus.eng_done = 1'b0; bus.dst_req_ready = 1'b0; bus.dst_done = 1'b0;
    forever begin
      @(negedge clk);
      kill = reset || abort;
      if (src_stalled && (bus.src_req_valid !== 1'b1 || bus.src_req_addr !== src_hold_addr)) stab_err++;
      if (dst_stalled && (bus.dst_req_valid !== 1'b1 || bus.dst_req_addr !== dst_hold_addr)) stab_err++;
      src_stalled = 1'b0;
      dst_stalled = 1'b0;

      bus.src_done = 1'b0;     if (src_dly > 0) begin src_dly--; bus.src_done     = (src_dly == 0); end
      bus.dst_done = 1'b0;     if (dst_dly > 0) begin dst_dly--; bus.dst_done     = (dst_dly == 0); end
      bus.eng_done = 1'b0;     if (eng_dly > 0) begin eng_dly--; bus.eng_done     = (eng_dly == 0); end
      bus.eng_key_done = 1'b0; if (key_dly > 0) begin key_dly--; bus.eng_key_done = (key_dly == 0); end

      if (bus.eng_key_start) begin ev_log.push_back(EV_KEY); key_dly = key_lat; end
      if (bus.eng_start)     begin ev_log.push_back(EV_ENG); eng_dly = eng_lat; end
      if (done)              ev_log.push_back(EV_DONE);

      bus.src_req_ready = 1'b0;
      if (bus.src_req_valid) begin
        if (src_new) begin src_stall = int'($urandom_range(stall_max, stall_min)); src_new = 1'b0; end
        if (src_stall > 0) begin
          src_stall--;
          if (!kill) begin src_stalled = 1'b1; src_hold_addr = bus.src_req_addr; end
        end else begin
          bus.src_req_ready = 1'b1;
          src_new = 1'b1;
          if (!kill) begin
            src_log.push_back(bus.src_req_addr);
            ev_log.push_back(EV_SRC);
            if (same_cyc) bus.src_done = 1'b1;
            else          src_dly = src_lat;
          end
        end
      end

      bus.dst_req_ready = 1'b0;
      if (bus.dst_req_valid) begin
        if (dst_new) begin dst_stall = int'($urandom_range(stall_max, stall_min)); dst_new = 1'b0; end
        if (dst_hold || dst_stall > 0) begin
          if (dst_stall > 0) dst_stall--;
          if (!kill) begin dst_stalled = 1'b1; dst_hold_addr = bus.dst_req_addr; end
        end else begin
          bus.dst_req_ready = 1'b1;
          dst_new = 1'b1;
          if (!kill) begin
            dst_log.push_back(bus.dst_req_addr);
            ev_log.push_back(EV_DST);
            dst_dly = dst_lat;
          end
        end
      end

      if (kill) begin
        src_new = 1'b1; dst_new = 1'b1;
        src_dly = 0; dst_dly = 0; eng_dly = 0; key_dly = 0;
      end
    end
  end

  // Reference: a job is [key] then src/eng/dst per block, then one done.
  task automatic build_model(input int n, input logic [31:0] s, input logic [31:0] d, input bit k);
    exp_ev.delete(); exp_src.delete(); exp_dst.delete();
    if (k && n > 0) exp_ev.push_back(EV_KEY);
    for (int i = 0; i < n; i++) begin
      exp_src.push_back(s + 32'(i * BLK));
      exp_dst.push_back(d + 32'(i * BLK));
      exp_ev.push_back(EV_SRC);
      exp_ev.push_back(EV_ENG);
      exp_ev.push_back(EV_DST);
    end
    exp_ev.push_back(EV_DONE);
  endtask

  // Caller is 1 time unit after a rising edge; returns likewise, one edge later.
  task automatic start_job(input int n, input logic [31:0] s, input logic [31:0] d, input bit k);
    ev_log.delete(); src_log.delete(); dst_log.delete();
    stab_err   = 0;
    start      = 1'b1;
    num_blocks = CNT_W'(n);
    src_base   = s;
    dst_base   = d;
    key_reload = k;
    @(posedge clk); #1;
    start      = 1'b0;
    num_blocks = CNT_W'($urandom);
    src_base   = $urandom;
    dst_base   = $urandom;
    key_reload = 1'($urandom);
  endtask

  task automatic finish_job(input int n, input logic [31:0] s, input logic [31:0] d, input bit k,
                            input int budget);
    int cyc, bad;
    cyc = 0;
    while (busy && cyc < budget) begin @(posedge clk); #1; cyc++; end
    chk("job_timeout", 64'(busy), 64'(0));
    repeat (2) begin @(posedge clk); #1; end
    build_model(n, s, d, k);
    chk("ev_len", 64'(ev_log.size()), 64'(exp_ev.size()));
    bad = 0;
    foreach (exp_ev[i]) if (i >= ev_log.size() || ev_log[i] != exp_ev[i]) bad++;
    chk("ev_order", 64'(bad), 64'(0));
    bad = (src_log.size() != exp_src.size()) ? 1 : 0;
    foreach (exp_src[i]) if (i < src_log.size() && src_log[i] !== exp_src[i]) bad++;
    chk("src_addrs", 64'(bad), 64'(0));
    bad = (dst_log.size() != exp_dst.size()) ? 1 : 0;
    foreach (exp_dst[i]) if (i < dst_log.size() && dst_log[i] !== exp_dst[i]) bad++;
    chk("dst_addrs", 64'(bad), 64'(0));
    chk("blocks_done", 64'(blocks_done), 64'(n));
    chk("req_stable", 64'(stab_err), 64'(0));
  endtask

  initial begin : main
    vec_t        tbl[6];
    int          cyc;
    logic [31:0] ls, ld;

    tbl[0] = '{1,  32'h0000_1000, 32'h0000_2000, 1'b0, 0, 32'h0000_1000, 32'h0000_2000, 1};
    tbl[1] = '{4,  32'h0000_0100, 32'h0000_0800, 1'b1, 0, 32'h0000_0130, 32'h0000_0830, 4};
    tbl[2] = '{3,  32'h0000_3000, 32'h0000_5000, 1'b0, 5, 32'h0000_3020, 32'h0000_5020, 3};
    tbl[3] = '{0,  32'h0000_0010, 32'h0000_0020, 1'b1, 0, 32'h0000_0000, 32'h0000_0000, 0};
    tbl[4] = '{2,  32'hFFFF_FFF0, 32'h7FFF_FFF0, 1'b0, 0, 32'h0000_0000, 32'h8000_0000, 2};
    tbl[5] = '{31, 32'h0000_0000, 32'h0000_0400, 1'b1, 0, 32'h0000_01E0, 32'h0000_05E0, 31};

    reset = 1'b1; start = 1'b0; abort = 1'b0; key_reload = 1'b0;
    num_blocks = '0; src_base = '0; dst_base = '0;
    repeat (3) @(posedge clk); #1;
    chk("rst_ctrl", 64'({busy, done, blocks_done, bus.src_req_valid, bus.dst_req_valid,
                         bus.eng_key_start, bus.eng_start}), 64'(0));
    chk("rst_addr", 64'({bus.src_req_addr, bus.dst_req_addr}), 64'(0));
    reset = 1'b0;
    @(posedge clk); #1;

    for (int t = 0; t < 6; t++) begin
      stall_min = tbl[t].stall;
      stall_max = tbl[t].stall;
      start_job(tbl[t].num, tbl[t].src, tbl[t].dst, tbl[t].key);
      if (tbl[t].num == 0)  chk("zero_done_lat", 64'(done), 64'(1));
      else if (tbl[t].key)  chk("key_start_lat", 64'(bus.eng_key_start), 64'(1));
      else                  chk("src_valid_lat", 64'(bus.src_req_valid), 64'(1));
      finish_job(tbl[t].num, tbl[t].src, tbl[t].dst, tbl[t].key, 3000);
      chk("tbl_blocks", 64'(blocks_done), 64'(tbl[t].blocks));
      if (tbl[t].num > 0) begin
        ls = (src_log.size() > 0) ? src_log[$] : '0;
        ld = (dst_log.size() > 0) ? dst_log[$] : '0;
        chk("tbl_last_src", 64'(ls), 64'(tbl[t].last_src));
        chk("tbl_last_dst", 64'(ld), 64'(tbl[t].last_dst));
      end
    end
    stall_min = 0; stall_max = 0;

    // Abort while block 2 sits in the engine.
    eng_lat = 8;
    start_job(4, 32'h200, 32'h600, 1'b0);
    cyc = 0;
    while (count_ev(EV_ENG) < 3 && cyc < 300) begin @(posedge clk); #1; cyc++; end
    chk("abort_in_run", 64'(count_ev(EV_ENG)), 64'(3));
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_idle", 64'({busy, bus.src_req_valid, bus.dst_req_valid}), 64'(0));
    repeat (12) begin @(posedge clk); #1; end
    chk("abort_no_done", 64'(count_ev(EV_DONE)), 64'(0));
    chk("abort_blocks", 64'(blocks_done), 64'(2));
    eng_lat = 1;
    start_job(3, 32'h1230, 32'h4560, 1'b1);
    finish_job(3, 32'h1230, 32'h4560, 1'b1, 500);

    // Reset while a store is stalled.
    dst_hold = 1'b1;
    start_job(3, 32'h7000, 32'hC000, 1'b0);
    cyc = 0;
    while (!bus.dst_req_valid && cyc < 100) begin @(posedge clk); #1; cyc++; end
    chk("store_reached", 64'(bus.dst_req_valid), 64'(1));
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_ctrl", 64'({busy, done, blocks_done, bus.src_req_valid, bus.dst_req_valid,
                            bus.eng_key_start, bus.eng_start}), 64'(0));
    chk("midrst_addr", 64'({bus.src_req_addr, bus.dst_req_addr}), 64'(0));
    reset = 1'b0;
    dst_hold = 1'b0;
    @(posedge clk); #1;

    // A start while busy must not disturb the running job.
    eng_lat = 3;
    start_job(2, 32'h4000, 32'h8000, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    chk("busy_at_restart", 64'(busy), 64'(1));
    start = 1'b1; num_blocks = 5'd7; src_base = 32'h9000; dst_base = 32'hA000; key_reload = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    finish_job(2, 32'h4000, 32'h8000, 1'b0, 500);
    eng_lat = 1;

    for (int j = 0; j < 30; j++) begin
      int          n;
      logic [31:0] s, d;
      bit          k;
      n = ($urandom_range(7, 0) == 0) ? 0 : int'($urandom_range(6, 1));
      s = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFC0 : $urandom;
      d = $urandom;
      k = 1'($urandom);
      stall_min = 0;
      stall_max = int'($urandom_range(3, 0));
      src_lat   = int'($urandom_range(3, 1));
      dst_lat   = int'($urandom_range(3, 1));
      eng_lat   = int'($urandom_range(3, 1));
      key_lat   = int'($urandom_range(4, 1));
      same_cyc  = 1'($urandom);
      start_job(n, s, d, k);
      finish_job(n, s, d, k, (n + 2) * 80);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
